// File: rtl/rca_nibble_seq.sv
// -----------------------------------------------------------------------------
// rca_nibble_seq
//   Multi-cycle sequencer that performs WIDTH-bit add/subtract on a single
//   external 4-bit ripple-carry adder slice. Operands are accepted over a
//   start valid/ready handshake. One nibble per cycle is sent to the slice,
//   LSB nibble first, and the slice carry-out is chained into the next nibble.
//   The result (sum, carry, signed overflow) is returned over a result
//   valid/ready handshake.
//
// Ports
//   clk, rst                 clock (rising edge), async active-high reset
//   start_valid/start_ready  request handshake (ready only in IDLE)
//   A, B, C_in, op_sub       operands, ADD carry-in, 1 = A-B
//   slice_A/B/Cin            drive to the external 4-bit slice (0 outside RUN)
//   slice_Sum/Cout           combinational return from the slice
//   res_valid/res_ready      result handshake
//   Sum_out, C_out, ovf      result, final carry (SUB: 1 = no borrow), overflow
// -----------------------------------------------------------------------------
module rca_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C_in,
  input  logic             op_sub,
  output logic [3:0]       slice_A,
  output logic [3:0]       slice_B,
  output logic             slice_Cin,
  input  logic [3:0]       slice_Sum,
  input  logic             slice_Cout,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] Sum_out,
  output logic             C_out,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Operand copies are shifted right one nibble per RUN cycle so the active
  // nibble always sits in bits [3:0]; the top nibble ends up there on the
  // last pass, which is where the sign bits are read for overflow.
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  // Partial sum of the nibbles completed so far; kept apart from r_sum so
  // the visible result only changes on completion.
  logic [WIDTH-5:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_run;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_acc_next;

  assign w_run      = (r_state == S_RUN);
  assign w_last     = w_run && (r_idx == IW'(NIB - 1));
  assign w_accept   = start_valid && (r_state == S_IDLE);
  assign w_acc_next = {slice_Sum, r_acc};

  assign start_ready = (r_state == S_IDLE);
  assign res_valid   = (r_state == S_DONE);
  assign slice_A     = w_run ? r_a[3:0] : 4'd0;
  assign slice_B     = w_run ? r_b[3:0] : 4'd0;
  assign slice_Cin   = w_run ? r_carry  : 1'b0;
  assign Sum_out     = r_sum;
  assign C_out       = r_cout;
  assign ovf         = r_ovf;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start_valid) begin
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Operand latch, nibble sequencing and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= {WIDTH{1'b0}};
      r_b     <= {WIDTH{1'b0}};
      r_carry <= 1'b0;
      r_idx   <= {IW{1'b0}};
      r_acc   <= {(WIDTH-4){1'b0}};
      r_sum   <= {WIDTH{1'b0}};
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a     <= A;
            // Subtraction is A + ~B + 1: invert B here, force carry-in to 1.
            r_b     <= op_sub ? ~B : B;
            r_carry <= op_sub ? 1'b1 : C_in;
            r_idx   <= {IW{1'b0}};
            r_acc   <= {(WIDTH-4){1'b0}};
          end
        end
        S_RUN: begin
          r_a     <= {4'd0, r_a[WIDTH-1:4]};
          r_b     <= {4'd0, r_b[WIDTH-1:4]};
          r_carry <= slice_Cout;
          r_acc   <= w_acc_next[WIDTH-1:4];
          if (w_last) begin
            r_idx  <= {IW{1'b0}};
            r_sum  <= w_acc_next;
            r_cout <= slice_Cout;
            // Operand signs equal and sum sign differs from them.
            r_ovf  <= (r_a[3] ~^ r_b[3]) & (slice_Sum[3] ^ r_a[3]);
          end else begin
            r_idx  <= r_idx + IW'(1);
          end
        end
        S_DONE: begin
          r_idx <= {IW{1'b0}};
        end
        default: begin
          r_idx <= {IW{1'b0}};
        end
      endcase
    end
  end

endmodule
